// File: rtl/nibble_serial_add_ctrl_pkg.sv
// Shared definitions for the nibble-serial add/subtract sequencer:
// sequencer state encoding and the width of the shared arithmetic slice.
package nibble_serial_add_ctrl_pkg;

  // Width of the shared ripple slice; operands are walked this many bits per cycle.
  localparam int NIB_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/nibble_serial_add_ctrl_rc4.sv
// rc4: 4-bit ripple-carry slice with block propagate/generate outputs.
// G/P are carry-in independent so the caller can fold them into flags.
module rc4
  import nibble_serial_add_ctrl_pkg::*;
(
  input  logic [NIB_W-1:0] i_a,
  input  logic [NIB_W-1:0] i_b,
  input  logic             i_cin,
  output logic [NIB_W-1:0] o_sum,
  output logic             o_cout,
  output logic             o_p_block,
  output logic             o_g_block
);

  logic w_c;
  logic w_g;

  // Ripple the carry bit by bit; a second chain seeded with 0 gives block generate.
  always_comb begin
    // NOTE: defaults first so every path assigns every output -- no latch is inferred.
    o_sum = '0;
    w_c   = i_cin;
    w_g   = 1'b0;
    for (int i = 0; i < NIB_W; i++) begin
      o_sum[i] = i_a[i] ^ i_b[i] ^ w_c;
      w_c      = (i_a[i] & i_b[i]) | (w_c & (i_a[i] ^ i_b[i]));
      w_g      = (i_a[i] & i_b[i]) | (w_g & (i_a[i] ^ i_b[i]));
    end
  end

  assign o_cout    = w_c;
  assign o_g_block = w_g;
  assign o_p_block = &(i_a ^ i_b);

endmodule

// File: rtl/nibble_serial_add_ctrl.sv
// Multi-cycle add/subtract: one rc4 slice is reused across all nibbles,
// LSB first, with the inter-nibble carry held in a flop. Valid/ready on
// both sides; equality, overflow and signed less-than flags on the result.
module nibble_serial_add_ctrl
  import nibble_serial_add_ctrl_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic             ctrl_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] data_result,
  output logic             cout,
  output logic             overflow,
  output logic             isNotEqual,
  output logic             isLessThan
);

  localparam int NNIB  = WIDTH / NIB_W;
  localparam int CNT_W = (NNIB > 1) ? $clog2(NNIB) : 1;
  localparam logic [CNT_W-1:0] LAST_NIB = CNT_W'(NNIB - 1);

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_a, r_bx, r_result;
  logic [CNT_W-1:0] r_count;
  logic             r_carry, r_sub, r_all_p, r_sa, r_sb;

  logic [NIB_W-1:0] w_sum;
  logic             w_cout, w_p_block, w_g_block;
  logic             w_accept, w_last, w_overflow;

  assign w_accept = (r_state == ST_IDLE) && in_valid;
  assign w_last   = (r_count == LAST_NIB);

  rc4 u_rc4 (
    .i_a       (r_a[NIB_W-1:0]),
    .i_b       (r_bx[NIB_W-1:0]),
    .i_cin     (r_carry),
    .o_sum     (w_sum),
    .o_cout    (w_cout),
    .o_p_block (w_p_block),
    .o_g_block (w_g_block)
  );

  // State register; reset aborts any operation in flight.
  always_ff @(posedge clock or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state decode: accept in IDLE, walk the nibbles in RUN, hand off in DONE.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE: if (in_valid)  w_state_nxt = ST_RUN;
      ST_RUN:  if (w_last)    w_state_nxt = ST_DONE;
      ST_DONE: if (out_ready) w_state_nxt = ST_IDLE;
      default:                w_state_nxt = ST_IDLE;
    endcase
  end

  // Datapath: latch operands on accept, then shift one nibble per RUN cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_a      <= '0;
      r_bx     <= '0;
      r_result <= '0;
      r_count  <= '0;
      r_carry  <= 1'b0;
      r_sub    <= 1'b0;
      r_all_p  <= 1'b1;
      r_sa     <= 1'b0;
      r_sb     <= 1'b0;
    end else if (w_accept) begin
      r_a     <= data_operandA;
      r_bx    <= ctrl_sub ? ~data_operandB : data_operandB;
      r_carry <= ctrl_sub;
      r_sub   <= ctrl_sub;
      r_count <= '0;
      r_all_p <= 1'b1;
    end else if (r_state == ST_RUN) begin
      r_a      <= r_a  >> NIB_W;
      r_bx     <= r_bx >> NIB_W;
      r_result <= {w_sum, r_result[WIDTH-1:NIB_W]};
      r_carry  <= w_cout;
      r_all_p  <= r_all_p & w_p_block;
      if (w_last) begin
        r_sa <= r_a[NIB_W-1];
        r_sb <= r_bx[NIB_W-1];
      end else begin
        r_count <= r_count + CNT_W'(1);
      end
    end
  end

  // Handshake outputs come from registered state; in_ready is also masked by reset.
  assign in_ready  = (r_state == ST_IDLE) && !reset;
  assign out_valid = (r_state == ST_DONE);

  // Flags: A == B exactly when every nibble of A + ~B propagates.
  assign w_overflow  = (r_sa == r_sb) && (r_result[WIDTH-1] != r_sa);
  assign data_result = r_result;
  assign cout        = r_carry;
  assign overflow    = w_overflow;
  assign isNotEqual  = r_sub & ~r_all_p;
  assign isLessThan  = r_sub & (r_result[WIDTH-1] ^ w_overflow);

  // The slice carry must agree with its own block generate/propagate.
  a_slice_carry : assert property (@(posedge clock) disable iff (reset)
    (r_state == ST_RUN) |-> (w_cout == (w_g_block | (w_p_block & r_carry))));

endmodule

// File: doc/nibble_serial_add_ctrl.md
Name: nibble_serial_add_ctrl

Overview:
Multi-cycle 32-bit add/subtract sequencer that time-shares a single 4-bit ripple slice (rc4) across 8 nibbles, LSB first, with the inter-nibble carry held in a flop. It forms a low-area arithmetic option for the ALU and exposes a valid/ready handshake on both input and output. It folds the slice's block-propagate output into an equality flag and derives the overflow and less-than flags.

Parameters:
WIDTH, 32, operand/result width; must be a multiple of 4.
NNIB, WIDTH/4, nibble count; derived, not overridable.

Ports:
clock  input  1  single clock, rising edge.
reset  input  1  asynchronous, active-high; clears all state.
in_valid  input  1  operation request.
in_ready  output  1  high only in IDLE with reset deasserted.
data_operandA  input  WIDTH  operand A; sampled on the accept edge.
data_operandB  input  WIDTH  operand B; sampled on the accept edge.
ctrl_sub  input  1  0 = A+B, 1 = A-B; sampled on the accept edge.
out_valid  output  1  result available; held until accepted.
out_ready  input  1  consumer accepts the result.
data_result  output  WIDTH  sum or difference.
cout  output  1  carry out of bit WIDTH-1. For subtract, 1 = no borrow.
overflow  output  1  signed overflow.
isNotEqual  output  1  subtract only: A != B. 0 for add.
isLessThan  output  1  subtract only: signed A < B. 0 for add.

Behaviour:
- Reset values: state=IDLE, count=0, carry=0, allP=1, all result and flag registers 0, out_valid=0, in_ready=0 while reset is high.
- States: IDLE, RUN, DONE. FSM output signals are decoded from registered state only.
- IDLE:
  - in_ready=1. On a clock edge with in_valid=1:
  - latch A, and latch Bx = ctrl_sub ? ~B : B
  - carry <= ctrl_sub, sub_r <= ctrl_sub, count <= 0, allP <= 1
  - go to RUN.
- RUN, per cycle:
  - Slice inputs: a = A[3:0], b = Bx[3:0], cin = carry (the low nibble of each shift register).
  - On the edge: A and Bx shift right by 4; result register shifts right by 4 with slice sum entering bits [WIDTH-1:WIDTH-4].
  - carry <= slice cout; allP <= allP & P_block; count <= count+1.
  - On the nibble where count = NNIB-1, before shifting, capture the operand sign bits A[3] and Bx[3] as sa and sb.
  - After the edge that processes nibble NNIB-1, go to DONE.
- Latency: acceptance edge E0. Nibble i is processed on edge E(i+1). out_valid rises after E8, i.e. exactly 8 cycles after acceptance.
- DONE:
  - out_valid=1, in_ready=0.
  - data_result = the result register; cout = carry.
  - overflow = (sa == sb) & (data_result[WIDTH-1] != sa).
  - isNotEqual = sub_r & ~allP, since all nibbles propagating for A+~B means A == B.
  - isLessThan = sub_r & (data_result[WIDTH-1] ^ overflow).
  - On an edge with out_ready=1, go to IDLE. Outputs hold stable while out_ready=0, for any duration.
- Throughput: one operation per 10 cycles minimum (accept, 8 run cycles, done handshake). No accept occurs in DONE, even if in_valid and out_ready are both high.
- in_valid outside IDLE is ignored. Operand changes after the accept edge have no effect.
- G_block from the slice is unused; leave it unconnected, or use it only for an assertion that slice cout equals G_block | (P_block & cin).
- Reset mid-RUN or mid-DONE aborts immediately: out_valid drops asynchronously, no partial result is ever presented. After reset deassertion the FSM is in IDLE with in_ready=1.
- count is $clog2(NNIB) bits wide; it never wraps within an operation.

Decomposition:
- Shared package/include:
  - state encoding constants ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2
  - NIB_W=4
- Single sub-module: one rc4 instance as the shared datapath slice. All sequencing, shifting and flag logic lives in this module.

Test Plan:
- Add 0x7FFFFFFF + 0x00000001, out_ready=1 -> out_valid 8 cycles after accept; result 0x80000000, overflow=1, cout=0, isNotEqual=0, isLessThan=0.
- Add 0xFFFFFFFF + 0x00000001 -> result 0x00000000, cout=1, overflow=0.
- Sub 0x00000005 - 0x00000005 -> result 0x00000000, cout=1, isNotEqual=0, isLessThan=0, overflow=0.
- Sub 0x00000003 - 0x00000007 -> result 0xFFFFFFFC, isNotEqual=1, isLessThan=1, cout=0. Sub 0x80000000 - 0x00000001 -> result 0x7FFFFFFF, overflow=1, isLessThan=1.
- Backpressure: hold out_ready=0 for 5 cycles with in_valid=1 and new operands -> result and flags stable, in_ready=0, second operation accepted only after the handshake and the return to IDLE.
- Assert reset during RUN (after the 4th nibble edge) -> out_valid=0 immediately; after release in_ready=1; next op 0x12345678 + 0x11111111 -> 0x23456789.
